fetch_sequencer: RTL and testbench

//  Owns the program-counter register and sequences instruction fetch around the

---
 rtl/fetch_sequencer_if.sv | 21 ++
 rtl/fetch_sequencer.sv | 106 ++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory req/ack port plus the
// valid/ready handshake that hands fetched words to decode.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr_out, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner and fetch sequencer: requests words from instruction
// memory, presents them to decode, and advances the PC from npc_in on acceptance.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus,
    output logic [31:0]        cur_pc,
    input  logic [31:0]        npc_in,
    input  logic               halt,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        retired
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_ISSUE,
        S_HALT,
        S_FAULT
    } state_t;

    // The FETCH cycle in which the counter holds this value is the last one allowed.
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        imem_req_q;
    logic        instr_valid_q;
    logic [31:0] instr_q;

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = cur_pc;
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = instr_valid_q;

    // NOTE: every register here uses <= so all branches see pre-edge values;
    // the output flags are updated together with the state they reflect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_BOOT;
            cur_pc        <= RESET_PC;
            instr_q       <= '0;
            retired       <= '0;
            wait_cnt      <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted        <= 1'b0;
            fault         <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state      <= S_FETCH;
                    imem_req_q <= 1'b1;
                end

                S_FETCH: begin
                    if (bus.imem_ack) begin
                        // Ack takes priority over a simultaneous terminal count.
                        instr_q       <= bus.imem_rdata;
                        wait_cnt      <= '0;
                        state         <= S_ISSUE;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else if (wait_cnt == LAST_WAIT) begin
                        wait_cnt   <= wait_cnt + 8'd1;
                        state      <= S_FAULT;
                        imem_req_q <= 1'b0;
                        fault      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_ISSUE: begin
                    if (bus.instr_ready) begin
                        cur_pc        <= npc_in;
                        retired       <= retired + 32'd1;
                        instr_valid_q <= 1'b0;
                        if (halt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state      <= S_FETCH;
                            imem_req_q <= 1'b1;
                        end
                    end
                end

                S_HALT, S_FAULT: begin
                    state <= state;
                end

                default: begin
                    state         <= S_BOOT;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table of fetch/issue transactions plus
// hand-written halt, timeout and reset-during-issue sequences.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cur_pc;
    logic [31:0] npc_in;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer_if ifc ();

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (ifc),
        .cur_pc  (cur_pc),
        .npc_in  (npc_in),
        .halt    (halt),
        .halted  (halted),
        .fault   (fault),
        .retired (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ack_dly;
        int          rdy_dly;
        logic [31:0] rdata;
        logic [31:0] npc;
        logic        halt;
        logic [31:0] exp_addr;
        logic [31:0] exp_retired;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Holds reset for two edges, checks reset values, releases, and returns
    // on the negedge where the first request should be visible.
    task automatic do_reset();
        rst = 1'b1;
        ifc.imem_ack = 1'b0;
        ifc.imem_rdata = '0;
        ifc.instr_ready = 1'b0;
        halt = 1'b0;
        npc_in = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, ifc.imem_req}, 32'd0);
        check("rst_valid", {31'b0, ifc.instr_valid}, 32'd0);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_pc", cur_pc, 32'h0);
        check("rst_retired", retired, 32'd0);
        check("rst_instr", ifc.instr_out, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'b0, ifc.imem_req}, 32'd1);
        check("first_addr", ifc.imem_addr, 32'h0);
    endtask

    // One fetch/issue transaction. Halt, stray acks and garbage npc_in are
    // driven on every cycle where they must be ignored.
    task automatic do_txn(input vec_t v);
        int k = 0;
        while (ifc.imem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", {31'b0, ifc.imem_req}, 32'd1);
        for (int i = 0; i <= v.ack_dly; i++) begin
            if (i > 0) @(negedge clk);
            check("req_hold", {31'b0, ifc.imem_req}, 32'd1);
            check("addr", ifc.imem_addr, v.exp_addr);
            check("valid_in_fetch", {31'b0, ifc.instr_valid}, 32'd0);
            ifc.imem_ack   = (i == v.ack_dly);
            ifc.imem_rdata = (i == v.ack_dly) ? v.rdata : 32'hDEAD_BEEF;
            halt           = 1'b1;
            npc_in         = 32'h5555_5555;
        end
        for (int j = 0; j <= v.rdy_dly; j++) begin
            @(negedge clk);
            check("valid", {31'b0, ifc.instr_valid}, 32'd1);
            check("req_in_issue", {31'b0, ifc.imem_req}, 32'd0);
            check("instr_out", ifc.instr_out, v.rdata);
            check("pc_in_issue", cur_pc, v.exp_addr);
            ifc.imem_ack    = (j != v.rdy_dly);
            ifc.imem_rdata  = 32'hBAD0_0000 | 32'(j);
            ifc.instr_ready = (j == v.rdy_dly);
            halt            = (j == v.rdy_dly) ? v.halt : 1'b1;
            npc_in          = (j == v.rdy_dly) ? v.npc : 32'h5555_5555;
        end
        @(negedge clk);
        ifc.imem_ack    = 1'b0;
        ifc.instr_ready = 1'b0;
        halt            = 1'b0;
        check("pc_after", cur_pc, v.npc);
        check("retired", retired, v.exp_retired);
        check("halted_after", {31'b0, halted}, {31'b0, v.halt});
        check("req_after", {31'b0, ifc.imem_req}, {31'b0, ~v.halt});
        check("valid_after", {31'b0, ifc.instr_valid}, 32'd0);
    endtask

    initial begin
        vec_t r0;
        vec_t r1;

        //            ack rdy rdata          npc            halt  addr           retired
        vecs[0] = '{0, 0, 32'h2000_0005, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'd1};
        vecs[1] = '{3, 2, 32'h1111_0001, 32'h0000_0004, 1'b0, 32'h0000_0001, 32'd2};
        vecs[2] = '{1, 0, 32'hAAAA_0002, 32'h0000_0010, 1'b0, 32'h0000_0004, 32'd3};
        vecs[3] = '{0, 1, 32'hBBBB_0003, 32'hFC00_0003, 1'b0, 32'h0000_0010, 32'd4};
        vecs[4] = '{2, 0, 32'hCCCC_0004, 32'hFFFF_FFFF, 1'b0, 32'hFC00_0003, 32'd5};
        vecs[5] = '{0, 0, 32'hDDDD_0005, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 32'd6};
        vecs[6] = '{0, 3, 32'hEEEE_0006, 32'h0000_0007, 1'b0, 32'h0000_0000, 32'd7};
        vecs[7] = '{1, 1, 32'h7777_0007, 32'h0000_0008, 1'b1, 32'h0000_0007, 32'd8};

        // Sequential fetch, delayed ack/ready, branch, jump, wrap, then halt.
        do_reset();
        for (int n = 0; n < 8; n++) do_txn(vecs[n]);

        // Halted: nothing moves for 20 cycles whatever the inputs do.
        for (int c = 0; c < 20; c++) begin
            ifc.imem_ack    = 1'b1;
            ifc.imem_rdata  = 32'h9999_0000 | 32'(c);
            ifc.instr_ready = 1'b1;
            halt            = 1'b1;
            npc_in          = 32'h4444_0000 | 32'(c);
            @(negedge clk);
            check("halt_req", {31'b0, ifc.imem_req}, 32'd0);
        end
        check("halt_flag", {31'b0, halted}, 32'd1);
        check("halt_pc", cur_pc, 32'h0000_0008);
        check("halt_retired", retired, 32'd8);
        check("halt_instr", ifc.instr_out, 32'h7777_0007);

        // Timeout: 15 FETCH cycles with no ack.
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            check("to_req", {31'b0, ifc.imem_req}, 32'd1);
            check("to_nofault", {31'b0, fault}, 32'd0);
            ifc.imem_ack = 1'b0;
            @(negedge clk);
        end
        check("to_fault", {31'b0, fault}, 32'd1);
        check("to_req_off", {31'b0, ifc.imem_req}, 32'd0);
        check("to_valid_off", {31'b0, ifc.instr_valid}, 32'd0);
        check("to_pc", cur_pc, 32'h0);
        for (int c = 0; c < 5; c++) begin
            ifc.imem_ack   = 1'b1;
            ifc.imem_rdata = 32'h6666_6666;
            @(negedge clk);
        end
        ifc.imem_ack = 1'b0;
        check("to_sticky", {31'b0, fault}, 32'd1);
        check("to_sticky_req", {31'b0, ifc.imem_req}, 32'd0);
        check("to_instr_kept", ifc.instr_out, 32'h0);

        // Ack on the 15th FETCH cycle wins over the timeout.
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            ifc.imem_ack   = (c == 15);
            ifc.imem_rdata = 32'h1234_5678;
            @(negedge clk);
        end
        ifc.imem_ack = 1'b0;
        check("ack15_nofault", {31'b0, fault}, 32'd0);
        check("ack15_valid", {31'b0, ifc.instr_valid}, 32'd1);
        check("ack15_instr", ifc.instr_out, 32'h1234_5678);

        // Reset while in ISSUE, then a stray ack in BOOT.
        do_reset();
        r0 = '{0, 0, 32'hCAFE_0001, 32'h0000_0003, 1'b0, 32'h0000_0000, 32'd1};
        do_txn(r0);
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 32'h0BAD_0002;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        check("pre_rst_valid", {31'b0, ifc.instr_valid}, 32'd1);
        check("pre_rst_instr", ifc.instr_out, 32'h0BAD_0002);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", {31'b0, ifc.instr_valid}, 32'd0);
        check("mid_rst_req", {31'b0, ifc.imem_req}, 32'd0);
        check("mid_rst_pc", cur_pc, 32'h0);
        check("mid_rst_retired", retired, 32'd0);
        check("mid_rst_instr", ifc.instr_out, 32'h0);
        rst            = 1'b0;
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        ifc.imem_ack = 1'b0;
        check("stray_req", {31'b0, ifc.imem_req}, 32'd1);
        check("stray_addr", ifc.imem_addr, 32'h0);
        check("stray_valid", {31'b0, ifc.instr_valid}, 32'd0);
        check("stray_instr", ifc.instr_out, 32'h0);
        r1 = '{0, 0, 32'h3000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'd1};
        do_txn(r1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
